// File: rtl/deparser_phv_seg_join.sv
// deparser_phv_seg_join: pairs PHVs from the last match-action stage with the
// header segments buffered at parse time, in arrival order, for the deparser.
// Ports: clk/aresetn (async active-low); phv_in/phv_valid_in/phv_ready_out;
//   segs_in/tuser_1st_in/segs_valid_in/segs_ready_out; registered output pair
//   phv_out/segs_out/tuser_1st_out with join_valid/join_ready;
//   join_cnt/ovf_cnt exist only when DEPARSER_JOIN_STATS_EN is defined.
module deparser_phv_seg_join #(
    parameter int C_AXIS_DATA_WIDTH  = 512,
    parameter int C_AXIS_TUSER_WIDTH = 128,
    parameter int C_NUM_SEGS         = 2,
    parameter int PKT_HDR_LEN        = (6+4+2)*8*8+256,
    parameter int FIFO_DEPTH_BITS    = 4
) (
    input  logic                                      clk,
    input  logic                                      aresetn,
    input  logic [PKT_HDR_LEN-1:0]                    phv_in,
    input  logic                                      phv_valid_in,
    output logic                                      phv_ready_out,
    input  logic [C_NUM_SEGS*C_AXIS_DATA_WIDTH-1:0]   segs_in,
    input  logic [C_AXIS_TUSER_WIDTH-1:0]             tuser_1st_in,
    input  logic                                      segs_valid_in,
    output logic                                      segs_ready_out,
    output logic [PKT_HDR_LEN-1:0]                    phv_out,
    output logic [C_NUM_SEGS*C_AXIS_DATA_WIDTH-1:0]   segs_out,
    output logic [C_AXIS_TUSER_WIDTH-1:0]             tuser_1st_out,
    output logic                                      join_valid,
`ifdef DEPARSER_JOIN_STATS_EN
    output logic [31:0]                               join_cnt,
    output logic [15:0]                               ovf_cnt,
`endif
    input  logic                                      join_ready
);

    localparam int SEGW = C_NUM_SEGS * C_AXIS_DATA_WIDTH;
    localparam int SEGE = SEGW + C_AXIS_TUSER_WIDTH;
    localparam int D    = 1 << FIFO_DEPTH_BITS;
    localparam int CW   = FIFO_DEPTH_BITS + 1;

    localparam logic [FIFO_DEPTH_BITS-1:0] P_ONE = 1;
    localparam logic [CW-1:0]              C_ONE = 1;
    localparam logic [CW-1:0]              C_FULL = CW'(D);

    typedef enum logic {S_EMPTY, S_HOLD} state_t;

    state_t state_q, state_d;

    logic [PKT_HDR_LEN-1:0]     phv_mem [D];
    logic [SEGE-1:0]            seg_mem [D];
    logic [FIFO_DEPTH_BITS-1:0] phv_wp, phv_rp, seg_wp, seg_rp;
    logic [CW-1:0]              phv_cnt, seg_cnt;

    logic phv_full, phv_empty, seg_full, seg_empty;
    logic phv_wr, seg_wr, load;

    assign phv_full  = (phv_cnt == C_FULL);
    assign seg_full  = (seg_cnt == C_FULL);
    assign phv_empty = (phv_cnt == '0);
    assign seg_empty = (seg_cnt == '0);

    assign phv_ready_out  = ~phv_full;
    assign segs_ready_out = ~seg_full;

    // A full FIFO still accepts a write in a cycle where the join pops it.
    assign phv_wr = phv_valid_in  & (~phv_full | load);
    assign seg_wr = segs_valid_in & (~seg_full | load);

    assign join_valid = (state_q == S_HOLD);

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        if (!phv_empty && !seg_empty &&
            (state_q == S_EMPTY || join_ready))
            load = 1'b1;
        unique case (state_q)
            S_EMPTY: if (load) state_d = S_HOLD;
            S_HOLD: begin
                if (load)            state_d = S_HOLD;
                else if (join_ready) state_d = S_EMPTY;
            end
            default: state_d = S_EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) state_q <= S_EMPTY;
        else          state_q <= state_d;
    end

    // Storage arrays are not reset; pointers and counts define validity.
    always_ff @(posedge clk) begin
        if (phv_wr) phv_mem[phv_wp] <= phv_in;
        if (seg_wr) seg_mem[seg_wp] <= {tuser_1st_in, segs_in};
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            phv_wp  <= '0;
            phv_rp  <= '0;
            phv_cnt <= '0;
            seg_wp  <= '0;
            seg_rp  <= '0;
            seg_cnt <= '0;
        end else begin
            if (phv_wr) phv_wp <= phv_wp + P_ONE;
            if (seg_wr) seg_wp <= seg_wp + P_ONE;
            if (load) begin
                phv_rp <= phv_rp + P_ONE;
                seg_rp <= seg_rp + P_ONE;
            end
            if (phv_wr && !load)      phv_cnt <= phv_cnt + C_ONE;
            else if (!phv_wr && load) phv_cnt <= phv_cnt - C_ONE;
            if (seg_wr && !load)      seg_cnt <= seg_cnt + C_ONE;
            else if (!seg_wr && load) seg_cnt <= seg_cnt - C_ONE;
        end
    end

    // Reading the slot being overwritten on a full-FIFO write returns the
    // old entry, since the memory update is non-blocking.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            phv_out       <= '0;
            segs_out      <= '0;
            tuser_1st_out <= '0;
        end else if (load) begin
            phv_out                   <= phv_mem[phv_rp];
            {tuser_1st_out, segs_out} <= seg_mem[seg_rp];
        end
    end

`ifdef DEPARSER_JOIN_STATS_EN
    logic phv_drop, seg_drop;

    assign phv_drop = phv_valid_in  & ~phv_wr;
    assign seg_drop = segs_valid_in & ~seg_wr;

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            join_cnt <= '0;
            ovf_cnt  <= '0;
        end else begin
            if (join_valid && join_ready) join_cnt <= join_cnt + 32'd1;
            ovf_cnt <= ovf_cnt + 16'(phv_drop) + 16'(seg_drop);
        end
    end
`endif

endmodule
